// File: rtl/mem_port_arbiter.sv
// Merges instruction port A and data port B onto one physical memory port, one transaction at a time.
// Optional build macro ARB_ROUND_ROBIN_EN replaces fixed B-priority and the starvation counter with round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [1:0]        a_wmask,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_resp,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [1:0]        b_wmask,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_resp,
  output logic [DATA_W-1:0] b_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [1:0]        pmem_wmask,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic              a_req, b_req, grant_b;
  logic              sel_b_q, wr_q;
  logic [1:0]        wmask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_b set means B has priority at the next contended arbitration
  logic rr_b;

  always_comb begin
    grant_b = b_req;
    if (a_req && b_req) grant_b = rr_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_b <= 1'b1;
    end else if (state == IDLE && (a_req || b_req)) begin
      rr_b <= ~grant_b;
    end
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  always_comb begin
    grant_b = b_req;
    if (a_req && b_req && starve_cnt == LIMIT_C) grant_b = 1'b0;
  end

  // Counts consecutive B grants that bypassed a waiting A; never exceeds the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!a_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_b) starve_cnt <= starve_cnt + 1'b1;
      else         starve_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_req || b_req) state_nxt = BUSY;
      BUSY:    if (pmem_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A read+write request is carried as a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_b_q <= 1'b0;
      wr_q    <= 1'b0;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && (a_req || b_req)) begin
        sel_b_q <= grant_b;
        wr_q    <= grant_b ? b_write : a_write;
        wmask_q <= grant_b ? b_wmask : a_wmask;
        addr_q  <= grant_b ? b_addr  : a_addr;
        wdata_q <= grant_b ? b_wdata : a_wdata;
      end
      if (state == BUSY && pmem_resp) begin
        rdata_q <= wr_q ? '0 : pmem_rdata;
      end
    end
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wmask = '0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    a_resp     = 1'b0;
    a_rdata    = '0;
    b_resp     = 1'b0;
    b_rdata    = '0;
    case (state)
      BUSY: begin
        pmem_read  = ~wr_q;
        pmem_write = wr_q;
        pmem_wmask = wmask_q;
        pmem_addr  = addr_q;
        pmem_wdata = wdata_q;
      end
      DONE: begin
        if (sel_b_q) begin
          b_resp  = 1'b1;
          b_rdata = rdata_q;
        end else begin
          a_resp  = 1'b1;
          a_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [1:0]    a_wmask = 0, b_wmask = 0;
  logic [AW-1:0] a_addr = 0, b_addr = 0;
  logic [DW-1:0] a_wdata = 0, b_wdata = 0;
  logic          a_resp, b_resp, pmem_read, pmem_write;
  logic [DW-1:0] a_rdata, b_rdata, pmem_wdata;
  logic [1:0]    pmem_wmask;
  logic [AW-1:0] pmem_addr;
  logic          pmem_resp = 1'b0;
  logic [DW-1:0] pmem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_read(a_read), .a_write(a_write), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_resp(a_resp), .a_rdata(a_rdata),
    .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_resp(b_resp), .b_rdata(b_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: answers mem_lat cycles after the strobe first appears
  int            mem_lat  = 1;
  bit            mem_hang = 0;
  logic [DW-1:0] mem_data = 16'h0;
  int            wait_cnt = 0;

  always @(negedge clk) begin
    if ((pmem_read || pmem_write) && !pmem_resp && !mem_hang) begin
      wait_cnt++;
      if (wait_cnt == mem_lat + 1) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_data;
      end
    end else begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      wait_cnt   = 0;
    end
  end

  // Reference model: one outstanding transaction, a response slot, and arbitration history
  bit            m_txn = 0, m_wr = 0, m_port = 0, m_rr = 1;
  logic [1:0]    m_mask = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0, m_resp_data = 0;
  int            m_resp_port = -1;
  int            m_streak = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_txn = 0; m_resp_port = -1; m_streak = 0; m_rr = 1;
    end else begin
      bit ar, br, win;
      ar = a_read | a_write;
      br = b_read | b_write;
      win = 0;
      if (m_resp_port >= 0) begin
        m_resp_port = -1;
      end else if (m_txn) begin
        if (pmem_resp) begin
          m_txn = 0;
          m_resp_port = m_port ? 1 : 0;
          m_resp_data = m_wr ? '0 : pmem_rdata;
        end
      end else if (ar || br) begin
`ifdef ARB_ROUND_ROBIN_EN
        win  = (ar && br) ? m_rr : br;
        m_rr = !win;
`else
        win = (ar && br) ? (m_streak < LIMIT) : br;
        if (win) begin
          if (ar) m_streak++;
        end else begin
          m_streak = 0;
        end
`endif
        m_txn   = 1;
        m_port  = win;
        m_wr    = win ? b_write : a_write;
        m_mask  = win ? b_wmask : a_wmask;
        m_addr  = win ? b_addr  : a_addr;
        m_wdata = win ? b_wdata : a_wdata;
      end
      if (!ar) m_streak = 0;
    end
  end

  int            resp_log[$];
  bit            cap_read = 0, cap_write = 0;
  logic [1:0]    cap_wmask = 0;
  logic [AW-1:0] cap_addr = 0;
  logic [DW-1:0] cap_wdata = 0;

  always @(posedge clk) begin
    #1;
    chk("pmem_read",  pmem_read,  m_txn && !m_wr);
    chk("pmem_write", pmem_write, m_txn && m_wr);
    chk("pmem_wmask", pmem_wmask, m_txn ? m_mask : 2'b00);
    chk("pmem_addr",  pmem_addr,  m_txn ? m_addr : 16'h0);
    chk("pmem_wdata", pmem_wdata, m_txn ? m_wdata : 16'h0);
    chk("a_resp",     a_resp,     m_resp_port == 0);
    chk("b_resp",     b_resp,     m_resp_port == 1);
    chk("a_rdata",    a_rdata,    (m_resp_port == 0) ? m_resp_data : 16'h0);
    chk("b_rdata",    b_rdata,    (m_resp_port == 1) ? m_resp_data : 16'h0);
    if (a_resp) resp_log.push_back(0);
    if (b_resp) resp_log.push_back(1);
    if (pmem_read || pmem_write) begin
      cap_read  = pmem_read;
      cap_write = pmem_write;
      cap_wmask = pmem_wmask;
      cap_addr  = pmem_addr;
      cap_wdata = pmem_wdata;
    end
  end

  task automatic wait_resp(input string name, input bit port, input int budget, output int cycles);
    bit got;
    got = 0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(posedge clk); #2;
      cycles++;
      got = port ? b_resp : a_resp;
    end
    chk(name, got, 1'b1);
  endtask

  task automatic clear_caps();
    cap_read = 0; cap_write = 0; cap_wmask = 0; cap_addr = 0; cap_wdata = 0;
    resp_log.delete();
  endtask

  int cyc;
  int exp_order[10];
  int guard;

  initial begin
    #1;
    chk("reset_pmem_read", pmem_read, 1'b0);
    chk("reset_resps", {a_resp, b_resp}, 2'b00);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;

    // 1: single A read, memory answers two cycles after strobe
    clear_caps();
    mem_lat = 2; mem_data = 16'h1234;
    a_read = 1; a_addr = 16'h0040;
    @(posedge clk); #2;
    chk("t1_strobe_next_cycle", {pmem_read, pmem_write}, 2'b10);
    chk("t1_addr", pmem_addr, 16'h0040);
    wait_resp("t1_a_resp_timeout", 0, 20, cyc);
    a_read = 0;
    chk("t1_latency", cyc + 1, 4);
    chk("t1_a_rdata", a_rdata, 16'h1234);
    chk("t1_b_resp", b_resp, 1'b0);
    @(posedge clk); #2;

    // 2: simultaneous A read and B write, B served first
    clear_caps();
    mem_lat = 1; mem_data = 16'h7777;
    a_read = 1; a_addr = 16'h0010;
    b_write = 1; b_addr = 16'h2000; b_wdata = 16'hBEEF; b_wmask = 2'b01;
    wait_resp("t2_b_resp_timeout", 1, 20, cyc);
    b_write = 0;
    chk("t2_b_wr_strobe", {cap_read, cap_write}, 2'b01);
    chk("t2_b_addr", cap_addr, 16'h2000);
    chk("t2_b_wdata", cap_wdata, 16'hBEEF);
    chk("t2_b_wmask", cap_wmask, 2'b01);
    chk("t2_b_rdata", b_rdata, 16'h0);
    wait_resp("t2_a_resp_timeout", 0, 20, cyc);
    a_read = 0;
    chk("t2_a_addr", cap_addr, 16'h0010);
    chk("t2_a_rdata", a_rdata, 16'h7777);
    chk("t2_order_len", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      chk("t2_order_first", resp_log[0], 1);
      chk("t2_order_second", resp_log[1], 0);
    end
    @(posedge clk); #2;

    // 3: both ports held pending continuously
    clear_caps();
    mem_lat = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    a_read = 1; a_addr = 16'h0100;
    b_read = 1; b_addr = 16'h1100;
    guard = 0;
    while (resp_log.size() < 10 && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    a_read = 0; b_read = 0;
    chk("t3_grant_count", resp_log.size(), 10);
    for (int i = 0; i < 10 && i < resp_log.size(); i++)
      chk($sformatf("t3_grant_%0d", i), resp_log[i], exp_order[i]);
    @(posedge clk); #2;

    // 4: B address changes while its transaction is in flight
    clear_caps();
    mem_lat = 3; mem_data = 16'h4321;
    b_read = 1; b_addr = 16'h3000;
    @(posedge clk); #2;
    b_addr = 16'h3002;
    @(posedge clk); #2;
    chk("t4_addr_held", pmem_addr, 16'h3000);
    wait_resp("t4_b_resp_timeout", 1, 20, cyc);
    b_read = 0;
    chk("t4_addr_final", cap_addr, 16'h3000);
    chk("t4_b_rdata", b_rdata, 16'h4321);
    @(posedge clk); #2;

    // 5: reset while BUSY with memory never answering
    clear_caps();
    mem_hang = 1;
    b_read = 1; b_addr = 16'h0200;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("t5_busy_strobe", pmem_read, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("t5_async_addr", pmem_addr, 16'h0);
    chk("t5_async_resps", {a_resp, b_resp}, 2'b00);
    b_read = 0; b_addr = 0; mem_hang = 0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    resp_log.delete();
    repeat (5) @(posedge clk);
    #2;
    chk("t5_no_stray_resp", resp_log.size(), 0);
    chk("t5_idle_strobe", {pmem_read, pmem_write}, 2'b00);

    // 6: read and write both set on B is treated as a write
    clear_caps();
    mem_lat = 1; mem_data = 16'hAAAA;
    b_read = 1; b_write = 1; b_addr = 16'h0100; b_wdata = 16'h5555; b_wmask = 2'b11;
    wait_resp("t6_b_resp_timeout", 1, 20, cyc);
    b_read = 0; b_write = 0;
    chk("t6_strobe_kind", {cap_read, cap_write}, 2'b01);
    chk("t6_addr", cap_addr, 16'h0100);
    chk("t6_b_rdata_zero", b_rdata, 16'h0);
    repeat (3) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
